if_id_queue: RTL and testbench

//  Parametrised fetch-decode decoupling queue: DEPTH-entry FIFO of {pc, instruction, prediction}

---
 rtl/if_id_queue.sv | 93 +++++++++
 tb/tb_if_id_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch/decode decoupling FIFO of {pc, instruction, prediction}
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic              in_pred,
    input  logic              discard,
    input  logic              id_stall,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              out_pred,
    output logic [CNT_W-1:0]  count
);

    // A single-entry queue still needs a one-bit pointer; it simply never moves.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [0:DEPTH-1];
    logic [INST_W-1:0] inst_mem [0:DEPTH-1];
    logic              pred_mem [0:DEPTH-1];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  occ;
    logic              push;
    logic              pop;
    logic              not_empty;

    // Handshake and output decode look only at registered occupancy and storage.
    always_comb begin
        not_empty = (occ != '0);
        in_ready  = (occ != FULL_CNT);
        out_valid = not_empty;
        out_pc    = '0;
        out_inst  = '0;
        out_pred  = 1'b0;
        if (not_empty) begin
            out_pc   = pc_mem[rd_ptr];
            out_inst = inst_mem[rd_ptr];
            out_pred = pred_mem[rd_ptr];
        end
        // A flush from EX cancels both sides of the transfer in the same cycle.
        push  = in_valid & in_ready & ~discard;
        pop   = not_empty & ~id_stall & ~discard;
        count = occ;
    end

    // Storage is not reset: an entry only becomes visible once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
            pred_mem[wr_ptr] <= in_pred;
        end
    end

    // Pointers and occupancy; full/empty come from the count, never from pointer compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (discard) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue (DEPTH=4 and DEPTH=1)
module tb_if_id_queue;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic        a_in_valid, a_in_ready, a_in_pred, a_discard, a_id_stall;
    logic        a_out_valid, a_out_pred;
    logic [31:0] a_in_pc, a_in_inst, a_out_pc, a_out_inst;
    logic [2:0]  a_count;

    // DEPTH=1 instance
    logic        b_in_valid, b_in_ready, b_in_pred, b_discard, b_id_stall;
    logic        b_out_valid, b_out_pred;
    logic [31:0] b_in_pc, b_in_inst, b_out_pc, b_out_inst;
    logic [0:0]  b_count;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_pc(a_in_pc), .in_inst(a_in_inst), .in_pred(a_in_pred),
        .discard(a_discard), .id_stall(a_id_stall),
        .out_valid(a_out_valid), .out_pc(a_out_pc), .out_inst(a_out_inst),
        .out_pred(a_out_pred), .count(a_count)
    );

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_pc(b_in_pc), .in_inst(b_in_inst), .in_pred(b_in_pred),
        .discard(b_discard), .id_stall(b_id_stall),
        .out_valid(b_out_valid), .out_pc(b_out_pc), .out_inst(b_out_inst),
        .out_pred(b_out_pred), .count(b_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    ent_t q[$];
    int   passed = 0;
    int   total  = 0;
    int   n_push = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare4();
        ent_t h;
        h = (q.size() != 0) ? q[0] : '0;
        chk("a_out_valid", 64'(a_out_valid), 64'(q.size() != 0));
        chk("a_out_pc",    64'(a_out_pc),    64'(h.pc));
        chk("a_out_inst",  64'(a_out_inst),  64'(h.inst));
        chk("a_out_pred",  64'(a_out_pred),  64'(h.pred));
        chk("a_count",     64'(a_count),     64'(q.size()));
        chk("a_in_ready",  64'(a_in_ready),  64'(q.size() != 4));
    endtask

    // One clock of the DEPTH=4 queue with a scoreboard queue as reference.
    task automatic step4(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                         input logic pr, input logic st, input logic dc);
        logic m_push, m_pop;
        a_in_valid = iv; a_in_pc = pc; a_in_inst = inst; a_in_pred = pr;
        a_id_stall = st; a_discard = dc;
        m_push = iv && (q.size() != 4) && !dc;
        m_pop  = (q.size() != 0) && !st && !dc;
        @(posedge clk); #1;
        if (dc) q.delete();
        else begin
            if (m_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back({pc, inst, pr});
                n_push++;
            end
        end
        compare4();
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        st;
        logic        dc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_ready;
        logic        e_count;
    } vec1_t;

    vec1_t tbl[10];

    initial begin
        a_in_valid = 0; a_in_pc = 0; a_in_inst = 0; a_in_pred = 0; a_discard = 0; a_id_stall = 0;
        b_in_valid = 0; b_in_pc = 0; b_in_inst = 0; b_in_pred = 0; b_discard = 0; b_id_stall = 0;

        tbl[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 32'h14, 1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1, 32'h18, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 32'h1C, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare4();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Pass-through
        step4(1, 32'h100, 32'h00500093, 1, 0, 0);
        chk("pass_pc",   64'(a_out_pc),   64'h100);
        chk("pass_inst", 64'(a_out_inst), 64'h00500093);
        chk("pass_pred", 64'(a_out_pred), 64'h1);
        step4(0, 0, 0, 0, 0, 0);
        chk("pass_empty", 64'(a_out_valid), 64'h0);

        // Fill under stall, fifth entry refused, then drain in order
        for (int i = 0; i < 4; i++) step4(1, 32'(i * 4), 32'hA000 + 32'(i), i[0], 1, 0);
        chk("fill_count", 64'(a_count), 64'h4);
        chk("fill_ready", 64'(a_in_ready), 64'h0);
        step4(1, 32'h10, 32'hBAD, 1, 1, 0);
        chk("fill_hold", 64'(a_count), 64'h4);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", 64'(a_out_pc), 64'(i * 4));
            step4(0, 0, 0, 0, 0, 0);
        end
        chk("drain_empty", 64'(a_count), 64'h0);

        // Full with ID consuming: pop happens, push refused, push resumes next cycle
        for (int i = 0; i < 4; i++) step4(1, 32'h200 + 32'(i * 4), 32'h1, 0, 1, 0);
        step4(1, 32'h300, 32'h2, 0, 0, 0);
        chk("full_pop_count", 64'(a_count), 64'h3);
        step4(1, 32'h300, 32'h2, 0, 1, 0);
        chk("full_resume", 64'(a_count), 64'h4);
        for (int i = 0; i < 4; i++) step4(0, 0, 0, 0, 0, 0);

        // Simultaneous push and pop at count=2
        step4(1, 32'h400, 32'h3, 0, 1, 0);
        step4(1, 32'h404, 32'h4, 1, 1, 0);
        step4(1, 32'h408, 32'h5, 0, 0, 0);
        chk("pushpop_count", 64'(a_count), 64'h2);

        // Discard at count=3 with a push and pop offered in the same cycle
        step4(1, 32'h40C, 32'h6, 0, 1, 0);
        step4(1, 32'hDEAD, 32'hDEAD, 1, 0, 1);
        chk("discard_count", 64'(a_count), 64'h0);
        chk("discard_pc", 64'(a_out_pc), 64'h0);
        chk("discard_ready", 64'(a_in_ready), 64'h1);
        step4(0, 0, 0, 0, 0, 0);
        chk("discard_gone", 64'(a_out_valid), 64'h0);

        // Random traffic against the scoreboard
        n_push = 0;
        for (int i = 0; i < 200; i++) begin
            step4($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
        end
        chk("random_wraps", 64'(n_push >= 40), 64'h1);

        // Asynchronous reset mid-run with three entries held
        q.delete();
        step4(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step4(1, 32'h500 + 32'(i), 32'h7, 1, 1, 0);
        chk("pre_reset_count", 64'(a_count), 64'h3);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        compare4();
        @(negedge clk); rst_n = 1'b1;
        a_in_valid = 0;

        // Single-entry queue from table
        for (int i = 0; i < 10; i++) begin
            b_in_valid = tbl[i].iv; b_in_pc = tbl[i].pc; b_in_inst = tbl[i].pc + 32'h1000;
            b_in_pred = tbl[i].pc[2]; b_id_stall = tbl[i].st; b_discard = tbl[i].dc;
            @(posedge clk); #1;
            chk("d1_valid", 64'(b_out_valid), 64'(tbl[i].e_valid));
            chk("d1_pc",    64'(b_out_pc),    64'(tbl[i].e_pc));
            chk("d1_inst",  64'(b_out_inst),  tbl[i].e_valid ? 64'(tbl[i].e_pc + 32'h1000) : 64'h0);
            chk("d1_pred",  64'(b_out_pred),  64'(tbl[i].e_pc[2]));
            chk("d1_ready", 64'(b_in_ready),  64'(tbl[i].e_ready));
            chk("d1_count", 64'(b_count),     64'(tbl[i].e_count));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
